// File: rtl/fp_twiddle_mul_pkg.sv
// Shared FP32 field layout, special encodings and controller state encoding
// for the twiddle multiplier.
package fp_twiddle_mul_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_W   = 23;
  localparam int BIAS     = 127;

  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [30:0] INF_MAG  = 31'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/fp_twiddle_mul_fp32_mul.sv
// Combinational FP32 multiply: denormals flush to +0, truncation,
// underflow to +0, overflow saturates to signed infinity, no NaN handling.
module fp32_mul
  import fp_twiddle_mul_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);
  logic [7:0]        ea_s;
  logic [7:0]        eb_s;
  logic              sign_s;
  logic [47:0]       mant_s;
  logic [24:0]       mant_hi_s;
  logic [22:0]       mant_lo_unused;
  logic [FRAC_W-1:0] frac_s;
  logic signed [9:0] exp_s;

  assign ea_s   = a[EXP_MSB:EXP_LSB];
  assign eb_s   = b[EXP_MSB:EXP_LSB];
  assign sign_s = a[SIGN_BIT] ^ b[SIGN_BIT];
  assign mant_s = {24'd0, 1'b1, a[FRAC_W-1:0]} * {24'd0, 1'b1, b[FRAC_W-1:0]};
  assign {mant_hi_s, mant_lo_unused} = mant_s;

  // A product of two [1,2) significands lies in [1,4); bit 47 picks the normalisation.
  assign frac_s = mant_hi_s[24] ? mant_hi_s[23:1] : mant_hi_s[22:0];
  assign exp_s  = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s})
                - $signed(10'(BIAS)) + $signed({9'd0, mant_hi_s[24]});

  // Result selection with zero flush, underflow and saturation.
  always_comb begin
    p = POS_ZERO;
    if (ea_s == 8'd0 || eb_s == 8'd0) begin
      p = POS_ZERO;
    end else if (exp_s <= 10'sd0) begin
      p = POS_ZERO;
    end else if (exp_s >= 10'sd255) begin
      p = {sign_s, INF_MAG};
    end else begin
      p = {sign_s, exp_s[7:0], frac_s};
    end
  end
endmodule

// File: rtl/fp_twiddle_mul.sv
// Iterative complex twiddle multiplier: four real partial products computed
// one per cycle on a shared FP32 multiplier, presented together with a tag.
module fp_twiddle_mul
  import fp_twiddle_mul_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a_re,
  input  logic [31:0]      a_im,
  input  logic [31:0]      w_re,
  input  logic [31:0]      w_im,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      p_rr,
  output logic [31:0]      p_ii,
  output logic [31:0]      p_ri,
  output logic [31:0]      p_ir,
  output logic [TAG_W-1:0] out_tag
);
  state_e           state_q;
  logic [1:0]       cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [31:0]      a_re_q, a_im_q, w_re_q, w_im_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [31:0]      op_a_s, op_b_s, prod_s;

  // Operand pair for the shared multiplier, ordered rr, ii, ri, ir.
  always_comb begin
    op_a_s = a_re_q;
    op_b_s = w_re_q;
    case (cnt_q)
      2'd0:    begin op_a_s = a_re_q; op_b_s = w_re_q; end
      2'd1:    begin op_a_s = a_im_q; op_b_s = w_im_q; end
      2'd2:    begin op_a_s = a_re_q; op_b_s = w_im_q; end
      2'd3:    begin op_a_s = a_im_q; op_b_s = w_re_q; end
      default: begin op_a_s = a_re_q; op_b_s = w_re_q; end
    endcase
  end

  fp32_mul u_mul (
    .a (op_a_s),
    .b (op_b_s),
    .p (prod_s)
  );

  // Controller, operand capture and product/output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_re_q      <= 32'd0;
      a_im_q      <= 32'd0;
      w_re_q      <= 32'd0;
      w_im_q      <= 32'd0;
      tag_q       <= '0;
      p_rr_q      <= 32'd0;
      p_ii_q      <= 32'd0;
      p_ri_q      <= 32'd0;
      p_ir_q      <= 32'd0;
      out_tag_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_re_q     <= a_re;
            a_im_q     <= a_im;
            w_re_q     <= w_re;
            w_im_q     <= w_im;
            tag_q      <= in_tag;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b0;
            state_q    <= MUL;
          end
        end
        MUL: begin
          case (cnt_q)
            2'd0:    p_rr_q <= prod_s;
            2'd1:    p_ii_q <= prod_s;
            2'd2:    p_ri_q <= prod_s;
            2'd3:    p_ir_q <= prod_s;
            default: p_rr_q <= p_rr_q;
          endcase
          if (cnt_q == 2'd3) begin
            out_valid_q <= 1'b1;
            out_tag_q   <= tag_q;
            cnt_q       <= 2'd0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          cnt_q       <= 2'd0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p_rr      = p_rr_q;
  assign p_ii      = p_ii_q;
  assign p_ri      = p_ri_q;
  assign p_ir      = p_ir_q;
  assign out_tag   = out_tag_q;
endmodule

// File: tb/tb_fp_twiddle_mul.sv
// Self-checking bench for fp_twiddle_mul: directed vector table, random
// vectors against an arithmetic reference, and multi-cycle handshake cases.
module tb_fp_twiddle_mul;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_re = 32'd0, a_im = 32'd0, w_re = 32'd0, w_im = 32'd0;
  logic [7:0]  in_tag = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] p_rr, p_ii, p_ri, p_ir;
  logic [7:0]  out_tag;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc[$];

  typedef struct {
    logic [31:0] ar, ai, wr, wi;
    logic [7:0]  tag;
    logic [31:0] err, eii, eri, eir;
  } vec_t;

  vec_t vecs[$];

  fp_twiddle_mul #(.TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .w_re(w_re), .w_im(w_im), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .p_rr(p_rr), .p_ii(p_ii), .p_ri(p_ri), .p_ir(p_ir), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_cyc.push_back(cyc);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference FP32 multiply from the arithmetic rules, on integers.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e;
    longint ma, mb, m, frac;
    logic s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    if (ea == 0 || eb == 0) return 32'h0000_0000;
    ma = (longint'(1) << 23) + longint'(a[22:0]);
    mb = (longint'(1) << 23) + longint'(b[22:0]);
    m  = ma * mb;
    e  = ea + eb - 127;
    if (m >= (longint'(1) << 47)) begin
      e    = e + 1;
      frac = (m >> 24) % (longint'(1) << 23);
    end else begin
      frac = (m >> 23) % (longint'(1) << 23);
    end
    if (e <= 0) return 32'h0000_0000;
    if (e >= 255) return {s, 31'h7F80_0000};
    return {s, e[7:0], frac[22:0]};
  endfunction

  function automatic vec_t mk_rand();
    vec_t v;
    v.ar = $urandom; v.ai = $urandom; v.wr = $urandom; v.wi = $urandom;
    if ($urandom_range(0, 3) == 0) v.ai[30:23] = 8'd0;
    v.tag = 8'($urandom);
    v.err = ref_mul(v.ar, v.wr);
    v.eii = ref_mul(v.ai, v.wi);
    v.eri = ref_mul(v.ar, v.wi);
    v.eir = ref_mul(v.ai, v.wr);
    return v;
  endfunction

  task automatic check_outputs(input string name, input vec_t v);
    chk({name, ".p_rr"}, p_rr, v.err);
    chk({name, ".p_ii"}, p_ii, v.eii);
    chk({name, ".p_ri"}, p_ri, v.eri);
    chk({name, ".p_ir"}, p_ir, v.eir);
    chk({name, ".tag"}, {24'd0, out_tag}, {24'd0, v.tag});
  endtask

  // Wait for in_ready, present one transaction, then expect out_valid 4 edges later.
  task automatic run_txn(input string name, input vec_t v);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, ".ready"}, {31'd0, in_ready}, 32'd1);
    a_re = v.ar; a_im = v.ai; w_re = v.wr; w_im = v.wi; in_tag = v.tag;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_re = $urandom; a_im = $urandom; w_re = $urandom; w_im = $urandom; in_tag = 8'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, ".latency"}, n, 32'd4);
    check_outputs(name, v);
  endtask

  initial begin
    vec_t v, vb;
    int n;
    logic [31:0] snap_rr;

    vecs.push_back('{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF00_0000, 8'h5A,
                     32'h3F00_0000, 32'hBF80_0000, 32'hBF00_0000, 32'h3F80_0000});
    vecs.push_back('{32'h3FC0_0000, 32'h0000_0000, 32'h3FC0_0000, 32'h0000_0000, 8'h11,
                     32'h4010_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{32'h7F00_0000, 32'h0080_0000, 32'h4000_0000, 32'h3F00_0000, 8'hC3,
                     32'h7F80_0000, 32'h0000_0000, 32'h7E80_0000, 32'h0100_0000});
    vecs.push_back('{32'h0000_0000, 32'h3F80_0000, 32'hC000_0000, 32'h3F80_0000, 8'hFF,
                     32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 32'hC000_0000});

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.p_rr", p_rr, 32'd0);
    chk("reset.p_ir", p_ir, 32'd0);
    chk("reset.tag", {24'd0, out_tag}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) run_txn($sformatf("dir%0d", i), vecs[i]);
    for (int i = 0; i < 20; i++) begin
      v = mk_rand();
      run_txn($sformatf("rnd%0d", i), v);
    end

    // Backpressure: hold the result, ignore a new request, then release.
    @(posedge clk); #1;
    out_ready = 1'b0;
    v = vecs[0];
    run_txn("bp", v);
    snap_rr = v.err;
    vb = mk_rand();
    for (int k = 0; k < 10; k++) begin
      a_re = vb.ar; a_im = vb.ai; w_re = vb.wr; w_im = vb.wi; in_tag = vb.tag;
      in_valid = (k == 3 || k == 4);
      @(posedge clk); #1;
      chk($sformatf("bp%0d.valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d.ready", k), {31'd0, in_ready}, 32'd0);
      check_outputs($sformatf("bp%0d", k), v);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release.valid", {31'd0, out_valid}, 32'd0);
    chk("bp.release.ready", {31'd0, in_ready}, 32'd1);
    chk("bp.release.p_rr", p_rr, snap_rr);

    // Back-to-back with in_valid held high: accepts 6 cycles apart.
    acc_cyc.delete();
    vb = mk_rand();
    a_re = vb.ar; a_im = vb.ai; w_re = vb.wr; w_im = vb.wi; in_tag = vb.tag;
    in_valid = 1'b1;
    n = 0;
    while (acc_cyc.size() < 2 && n < 30) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    chk("b2b.accepts", acc_cyc.size(), 32'd2);
    if (acc_cyc.size() >= 2) chk("b2b.period", acc_cyc[1] - acc_cyc[0], 32'd6);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check_outputs("b2b", vb);

    // Reset while the third product is being computed.
    @(posedge clk); #1;
    v = mk_rand();
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    a_re = v.ar; a_im = v.ai; w_re = v.wr; w_im = v.wi; in_tag = v.tag;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.p_rr", p_rr, 32'd0);
    chk("rst.p_ii", p_ii, 32'd0);
    chk("rst.p_ri", p_ri, 32'd0);
    chk("rst.p_ir", p_ir, 32'd0);
    chk("rst.tag", {24'd0, out_tag}, 32'd0);
    run_txn("post_rst", vecs[2]);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
